// File: rtl/regfile_param_if.sv
// Register file access bundle: read ports, two write ports and bulk-clear handshake.
interface regfile_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic                     we0;
  logic [ADDR_W-1:0]        wa0;
  logic [DATA_W-1:0]        wd0;
  logic                     we1;
  logic [ADDR_W-1:0]        wa1;
  logic [DATA_W-1:0]        wd1;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;

  modport master (
    output ra, we0, wa0, wd0, we1, wa1, wd1, clr_req,
    input  rd, clr_busy, clr_done
  );

  modport slave (
    input  ra, we0, wa0, wd0, we1, wa1, wd1, clr_req,
    output rd, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised multi-read, dual-write register file with sequenced bulk clear.
// Optional write-first forwarding enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int NUM_RD  = 2,
  parameter int R0_ZERO = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  regfile_param_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr0_ok, wr1_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.clr_busy = busy_q;
  assign bus.clr_done = done_q;

  assign wr0_ok = bus.we0 && !busy_q && !((R0_ZERO != 0) && (bus.wa0 == '0));
  assign wr1_ok = bus.we1 && !busy_q && !((R0_ZERO != 0) && (bus.wa1 == '0));

  // Port 1 is assigned last so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state_q == CLEAR) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr0_ok) mem[bus.wa0] <= bus.wd0;
      if (wr1_ok) mem[bus.wa1] <= bus.wd1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] q;

    assign a = bus.ra[g*ADDR_W +: ADDR_W];

    always_comb begin
      q = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (!busy_q) begin
        if (bus.we0 && (bus.wa0 == a)) q = bus.wd0;
        if (bus.we1 && (bus.wa1 == a)) q = bus.wd1;
      end
`endif
      if ((R0_ZERO != 0) && (a == '0)) q = '0;
    end

    assign bus.rd[g*DATA_W +: DATA_W] = q;
  end
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two DUTs (R0_ZERO=0 and 1) share stimulus and are
// checked every cycle against an array/countdown model plus directed literals.
module tb_regfile_param;
  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  regfile_param_if #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2)) bus0 ();
  regfile_param_if #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2)) bus1 ();

  assign bus1.ra      = bus0.ra;
  assign bus1.we0     = bus0.we0;
  assign bus1.wa0     = bus0.wa0;
  assign bus1.wd0     = bus0.wd0;
  assign bus1.we1     = bus0.we1;
  assign bus1.wa1     = bus0.wa1;
  assign bus1.wd1     = bus0.wd1;
  assign bus1.clr_req = bus0.clr_req;

  regfile_param #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .R0_ZERO(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  regfile_param #(.DATA_W(8), .ADDR_W(3), .NUM_RD(2), .R0_ZERO(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rdp(input int d, input int p);
    logic [15:0] v;
    v = (d == 0) ? bus0.rd : bus1.rd;
    return v[p*8 +: 8];
  endfunction

  // Model: plain arrays, and a count of registers still to be wiped.
  logic [7:0] m0 [8];
  logic [7:0] m1 [8];
  int         clr_left;
  bit         e_busy, e_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin m0[i] = 8'h00; m1[i] = 8'h00; end
      clr_left = 0; e_busy = 0; e_done = 0;
    end else begin
      e_done = 0;
      if (clr_left > 0) begin
        m0[8-clr_left] = 8'h00;
        m1[8-clr_left] = 8'h00;
        clr_left--;
        e_done = (clr_left == 0);
      end else begin
        if (bus0.we0) begin
          m0[bus0.wa0] = bus0.wd0;
          if (bus0.wa0 != 0) m1[bus0.wa0] = bus0.wd0;
        end
        if (bus0.we1) begin
          m0[bus0.wa1] = bus0.wd1;
          if (bus0.wa1 != 0) m1[bus0.wa1] = bus0.wd1;
        end
        if (bus0.clr_req) clr_left = 8;
      end
      e_busy = (clr_left > 0);
    end
  end

  function automatic logic [7:0] exp_rd(input int d, input logic [2:0] a);
    if (d == 1 && a == 0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
    if (!e_busy) begin
      if (bus0.we1 && bus0.wa1 == a) return bus0.wd1;
      if (bus0.we0 && bus0.wa0 == a) return bus0.wd0;
    end
`endif
    return (d == 0) ? m0[a] : m1[a];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < 2; p++) begin
        logic [5:0] rav;
        rav = bus0.ra;
        chk($sformatf("cyc_rd_d0_p%0d", p), rdp(0, p), exp_rd(0, rav[p*3 +: 3]));
        chk($sformatf("cyc_rd_d1_p%0d", p), rdp(1, p), exp_rd(1, rav[p*3 +: 3]));
      end
      chk("cyc_busy_d0", bus0.clr_busy, e_busy);
      chk("cyc_done_d0", bus0.clr_done, e_done);
      chk("cyc_busy_d1", bus1.clr_busy, e_busy);
      chk("cyc_done_d1", bus1.clr_done, e_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus0.we0 = 0; bus0.wa0 = 0; bus0.wd0 = 0;
    bus0.we1 = 0; bus0.wa1 = 0; bus0.wd1 = 0;
    bus0.clr_req = 0;
  endtask

  task automatic setra(input logic [2:0] a0, input logic [2:0] a1);
    bus0.ra = {a1, a0};
  endtask

  initial begin
    int nb, nd, donec;
    idle();
    setra(3'd0, 3'd1);
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
    #1;
    chk("reset_rd0", rdp(0, 0), 8'h00);
    chk("reset_busy", bus0.clr_busy, 1'b0);
    chk("reset_done", bus0.clr_done, 1'b0);

    // Dual write
    bus0.we0 = 1; bus0.wa0 = 3'd2; bus0.wd0 = 8'h11;
    bus0.we1 = 1; bus0.wa1 = 3'd6; bus0.wd1 = 8'h22;
    tick(); idle(); setra(3'd2, 3'd6); #1;
    chk("dual_r2", rdp(0, 0), 8'h11);
    chk("dual_r6", rdp(0, 1), 8'h22);
    chk("dual_r6_d1", rdp(1, 1), 8'h22);

    // Read-during-write on R5 (old value 0)
    setra(3'd5, 3'd5);
    bus0.we0 = 1; bus0.wa0 = 3'd5; bus0.wd0 = 8'hAA; #1;
`ifdef REGFILE_BYPASS_EN
    chk("rdw_before", rdp(0, 0), 8'hAA);
`else
    chk("rdw_before", rdp(0, 0), 8'h00);
`endif
    tick(); idle(); #1;
    chk("rdw_after", rdp(0, 0), 8'hAA);

    // Collision: port 1 wins
    bus0.we0 = 1; bus0.wa0 = 3'd5; bus0.wd0 = 8'hAA;
    bus0.we1 = 1; bus0.wa1 = 3'd5; bus0.wd1 = 8'hBB;
    tick(); idle(); #1;
    chk("collide_r5", rdp(0, 0), 8'hBB);

    // Register 0 write: hardwired zero on dut1
    setra(3'd0, 3'd0);
    bus0.we0 = 1; bus0.wa0 = 3'd0; bus0.wd0 = 8'hFF; #1;
    chk("r0z_before_d1", rdp(1, 0), 8'h00);
    tick(); idle(); #1;
    chk("r0z_after_d1", rdp(1, 0), 8'h00);
    chk("r0_after_d0", rdp(0, 0), 8'hFF);

    // Asynchronous reset mid-cycle
    bus0.we0 = 1; bus0.wa0 = 3'd3; bus0.wd0 = 8'h55;
    tick(); idle(); setra(3'd3, 3'd3); #1;
    chk("pre_rst_r3", rdp(0, 0), 8'h55);
    #2 rst_n = 0;
    #1;
    chk("async_rst_r3", rdp(0, 0), 8'h00);
    chk("async_rst_busy", bus0.clr_busy, 1'b0);
    chk("async_rst_done", bus0.clr_done, 1'b0);
    tick(); rst_n = 1; tick();

    // Bulk clear with write at edge k+3 dropped
    for (int i = 0; i < 4; i++) begin
      bus0.we0 = 1; bus0.wa0 = 3'(i);     bus0.wd0 = 8'hA0 + 8'(i);
      bus0.we1 = 1; bus0.wa1 = 3'(i + 4); bus0.wd1 = 8'hA4 + 8'(i);
      tick();
    end
    idle(); setra(3'd7, 3'd4); #1;
    chk("preload_r7", rdp(0, 0), 8'hA7);
    chk("preload_r4", rdp(0, 1), 8'hA4);
    bus0.clr_req = 1;
    tick();
    bus0.clr_req = 0;
    nb = 0; nd = 0; donec = -1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus0.clr_busy) nb++;
      if (bus0.clr_done) begin nd++; donec = c; end
      if (c == 2) begin bus0.we0 = 1; bus0.wa0 = 3'd7; bus0.wd0 = 8'h77; end
      if (c == 3) idle();
      tick();
    end
    chk("clr_busy_cycles", nb, 8);
    chk("clr_done_count", nd, 1);
    chk("clr_done_at_k8", donec, 8);
    for (int a = 0; a < 8; a++) begin
      setra(3'(a), 3'(a)); #1;
      chk($sformatf("clr_r%0d_d0", a), rdp(0, 0), 8'h00);
      chk($sformatf("clr_r%0d_d1", a), rdp(1, 1), 8'h00);
    end

    // Reset in the middle of a clear
    tick();
    bus0.we0 = 1; bus0.wa0 = 3'd6; bus0.wd0 = 8'h66;
    bus0.we1 = 1; bus0.wa1 = 3'd1; bus0.wd1 = 8'h31;
    tick(); idle();
    bus0.clr_req = 1;
    tick();
    bus0.clr_req = 0;
    repeat (3) tick();
    #2 rst_n = 0;
    #1;
    chk("midclr_busy", bus0.clr_busy, 1'b0);
    chk("midclr_done", bus0.clr_done, 1'b0);
    for (int a = 0; a < 8; a++) begin
      setra(3'(a), 3'(a)); #1;
      chk($sformatf("midclr_r%0d", a), rdp(0, 0), 8'h00);
    end
    tick(); tick();
    rst_n = 1;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      tick(); #1;
      if (bus0.clr_done) nd++;
    end
    chk("midclr_no_done", nd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
